timer_share_arb: RTL and testbench

Round-robin arbiter and sequencer for one shared down-counting delay timer. Up to NUM_REQ requesters (LED blinkers, debounce, power-up sequencing) request a delay of D ticks. The block grants the single counter to one requester, loads that requester's D, counts down, and returns a one-cycle done pulse. It replaces per-requester free-running counters with one time-multiplexed counter.

---
 rtl/timer_share_arb.sv | 144 ++++++++++++++
 tb/tb_timer_share_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_share_arb.sv
// Round-robin arbiter that time-shares one down-counting delay timer among NUM_REQ requesters.
// Optional macro TIMER_ARB_PRESCALE_EN inserts a 0..PRESCALE_MAX prescaler in front of the counter.
module timer_share_arb #(
  parameter int NUM_REQ      = 4,
  parameter int CNT_WIDTH    = 25,
  parameter int PRESCALE_MAX = 49
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] dly_flat,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy
);

  localparam int IDX_W = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     ptr, ptr_nxt;
  logic [IDX_W-1:0]     gidx, gidx_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt, done_nxt;
  logic                 busy_nxt;
  logic [NUM_REQ-1:0]   elig;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick;
  logic                 own_req;
  logic                 tick;
  logic                 grant_edge;
  logic                 finish;

  // A requester whose done pulse is showing cannot win again until it has had a chance to drop req.
  assign elig       = req & ~done;
  assign own_req    = req[gidx];
  assign grant_edge = (state == IDLE) && pick_vld;
  assign finish     = (state == RUN) && own_req && tick && (cnt == '0);

  // Search ptr, ptr+1, ... with wrap; descending loop so the nearest hit wins.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick     = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (elig[j[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = j[IDX_W-1:0];
      end
    end
  end

`ifdef TIMER_ARB_PRESCALE_EN
  localparam int PS_W = (PRESCALE_MAX < 1) ? 1 : $clog2(PRESCALE_MAX + 1);

  logic [PS_W-1:0] pscnt;

  // Prescaler phase is realigned on every grant so each grant lasts an exact multiple of the period.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                        pscnt <= '0;
    else if (grant_edge)                   pscnt <= '0;
    else if (pscnt == PS_W'(PRESCALE_MAX)) pscnt <= '0;
    else                                   pscnt <= pscnt + 1'b1;
  end

  assign tick = (pscnt == PS_W'(PRESCALE_MAX));
`else
  assign tick = (PRESCALE_MAX >= 0) | 1'b1;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      gidx  <= '0;
      cnt   <= '0;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gidx  <= gidx_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = RUN;
          gidx_nxt  = pick;
          ptr_nxt   = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          cnt_nxt   = dly_flat[int'(pick)*CNT_WIDTH +: CNT_WIDTH];
        end
      end
      RUN: begin
        if (!own_req) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt  = '0;
    done_nxt = '0;
    busy_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_nxt[pick] = 1'b1;
          busy_nxt      = 1'b1;
        end
      end
      RUN: begin
        if (finish) begin
          done_nxt[gidx] = 1'b1;
        end else if (own_req) begin
          gnt_nxt  = gnt;
          busy_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_share_arb.sv
// Bench for timer_share_arb: grant-length/ownership reference model plus directed and random traffic.
module tb_timer_share_arb;

  localparam int N  = 4;
  localparam int W  = 25;
  localparam int PM = 3;
`ifdef TIMER_ARB_PRESCALE_EN
  localparam int PS = PM + 1;
`else
  localparam int PS = 1;
`endif

  logic           sys_clk   = 1'b0;
  logic           sys_rst_n = 1'b0;
  logic [N-1:0]   req       = '0;
  logic [N*W-1:0] dly_flat  = '0;
  logic [N-1:0]   gnt, done;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the timer and how many cycles its grant still has.
  int           m_owner = -1;
  longint       m_left  = 0;
  int           m_ptr   = 0;
  logic [N-1:0] e_gnt   = '0;
  logic [N-1:0] e_done  = '0;
  logic         e_busy  = 1'b0;

  timer_share_arb #(.NUM_REQ(N), .CNT_WIDTH(W), .PRESCALE_MAX(PM)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req      (req),
    .dly_flat (dly_flat),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_dly(input int i, input logic [W-1:0] d);
    dly_flat[i*W +: W] = d;
  endtask

  task automatic wait_gnt(output int idx, output int waited);
    idx    = -1;
    waited = 0;
    while (gnt == '0 && waited < 300) begin
      tick();
      waited++;
    end
    if (gnt == '0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout: no grant after %0d cycles", waited);
    end else begin
      for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
    end
  endtask

  task automatic measure(input int idx, output int len);
    len = 0;
    if (idx >= 0) begin
      while (gnt[idx] && len < 5000) begin
        len++;
        tick();
      end
    end
  endtask

  // Model update on every active edge, using the inputs present at that edge.
  initial forever begin
    @(posedge sys_clk or negedge sys_rst_n);
    if (!sys_rst_n) begin
      m_owner = -1; m_left = 0; m_ptr = 0;
      e_gnt = '0; e_done = '0; e_busy = 1'b0;
    end else begin
      logic [N-1:0] elig;
      int nd;
      elig = req & ~e_done;
      nd   = -1;
      if (m_owner >= 0) begin
        if (!req[m_owner]) m_owner = -1;
        else if (m_left == 1) begin
          nd      = m_owner;
          m_owner = -1;
        end else m_left--;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (elig[j]) begin
            m_owner = j;
            m_left  = (longint'(dly_flat[j*W +: W]) + 1) * PS;
            m_ptr   = (j + 1) % N;
            break;
          end
        end
      end
      e_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_busy = (m_owner >= 0);
      e_done = (nd >= 0) ? (N'(1) << nd) : '0;
    end
  end

  initial forever begin
    @(negedge sys_clk);
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("done", 32'(done), 32'(e_done));
    check("busy", 32'(busy), 32'(e_busy));
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, w, len, order[4];
    logic saw_done;

    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    #2 sys_rst_n = 1'b1;
    tick();

    // Single request, D=5
    set_dly(1, 5);
    req = 4'b0010;
    wait_gnt(idx, w);
    check("single_idx", idx, 1);
    measure(1, len);
    check("single_len", len, 6 * PS);
    check("single_done", 32'(done), 32'h2);
    check("single_busy_fall", 32'(busy), 32'h0);
    req = '0;
    tick();
    check("single_done_one_cycle", 32'(done), 32'h0);

    // D=0
    set_dly(3, 0);
    req = 4'b1000;
    wait_gnt(idx, w);
    check("d0_idx", idx, 3);
    measure(3, len);
    check("d0_len", len, PS);
    check("d0_done", 32'(done), 32'h8);
    req = '0;
    tick();

    // Lone requester holding req through done is not re-granted in its done cycle
    set_dly(1, 1);
    req = 4'b0010;
    wait_gnt(idx, w);
    measure(1, len);
    check("hold_len", len, 2 * PS);
    wait_gnt(idx, w);
    check("hold_regrant_gap", w, 2);
    measure(1, len);
    req = '0;
    repeat (2) tick();

    // Round robin from reset
    sys_rst_n = 1'b0;
    #2 sys_rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) set_dly(i, 2);
    req = 4'hF;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(idx, w);
      order[g] = idx;
      if (g > 0) check("rr_gap", w, 1);
      measure(idx, len);
      check("rr_len", len, 3 * PS);
      if (idx >= 0) begin
        check("rr_done", 32'(done), 32'(N'(1) << idx));
        req[idx] = 1'b0;
      end
    end
    check("rr_order0", order[0], 0);
    check("rr_order1", order[1], 1);
    check("rr_order2", order[2], 2);
    check("rr_order3", order[3], 3);
    req = '0;
    tick();

    // Fairness across pointer wrap: move ptr to 3, then hold req[3] and req[0]
    set_dly(2, 0);
    req = 4'b0100;
    wait_gnt(idx, w);
    measure(2, len);
    req = '0;
    tick();
    set_dly(3, 1);
    set_dly(0, 1);
    req = 4'b1001;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(idx, w);
      order[g] = idx;
      if (g > 0) check("fair_gap", w, 1);
      measure(idx, len);
    end
    check("fair_order0", order[0], 3);
    check("fair_order1", order[1], 0);
    check("fair_order2", order[2], 3);
    check("fair_order3", order[3], 0);
    req = '0;
    repeat (3) tick();

    // Abort
    set_dly(1, 10);
    req = 4'b0010;
    wait_gnt(idx, w);
    repeat (4) tick();
    check("abort_still_granted", 32'(gnt), 32'h2);
    req = '0;
    tick();
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    saw_done = 1'b0;
    for (int c = 0; c < 12 * PS; c++) begin
      saw_done |= (done != '0);
      tick();
    end
    check("abort_no_done", 32'(saw_done), 32'h0);

    // Maximum delay value is accepted and counts without underflow
    set_dly(0, '1);
    req = 4'b0001;
    wait_gnt(idx, w);
    repeat (30) tick();
    check("maxd_granted", 32'(gnt), 32'h1);
    req = '0;
    repeat (2) tick();

    // Randomized traffic, including delay changes while a grant is running
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_dly(i, W'($urandom_range(0, 6)));
            req[i] = 1'b1;
          end
        end else if (done[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (gnt[i] && $urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
        if ($urandom_range(0, 15) == 0) set_dly(i, W'($urandom_range(0, 9)));
      end
      tick();
    end
    req = '0;
    repeat (3 * 10 * PS) tick();

    // Reset in the middle of a grant
    set_dly(0, 100);
    req = 4'b0001;
    wait_gnt(idx, w);
    repeat (10) tick();
    check("mid_run_granted", 32'(gnt), 32'h1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_reset_gnt", 32'(gnt), 32'h0);
    check("mid_reset_done", 32'(done), 32'h0);
    check("mid_reset_busy", 32'(busy), 32'h0);
    req = '0;
    tick();
    sys_rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("post_reset_idle", 32'(gnt), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
